// File: rtl/led_code_arbiter_if.sv
// Request/LED bundle between the status sources and the LED code arbiter.
// The arbiter takes the slave side; whoever drives requests takes the master side.
interface led_code_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int CODE_W  = 4
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*CODE_W-1:0] code;
  logic                      led;
  logic                      busy;
  logic [ID_W-1:0]           grant_id;
  logic                      done;

  modport master (output req, code, input led, busy, grant_id, done);
  modport slave  (input req, code, output led, busy, grant_id, done);
endinterface

// File: rtl/led_code_arbiter.sv
// Round-robin arbiter that lends one status LED to one requester at a time and
// blinks its code as N on-pulses followed by a long gap.
module led_code_arbiter #(
  parameter int CLK_FREQ_KHz = 50000,
  parameter int NUM_REQ      = 4,
  parameter int CODE_W       = 4,
  parameter int ON_MS        = 200,
  parameter int OFF_MS       = 200,
  parameter int GAP_MS       = 1000
) (
  input  logic              clk,
  input  logic              rst,
  led_code_arbiter_if.slave bus
);
  localparam int ON_CYC  = ON_MS * CLK_FREQ_KHz;
  localparam int OFF_CYC = OFF_MS * CLK_FREQ_KHz;
  localparam int GAP_CYC = GAP_MS * CLK_FREQ_KHz;
  localparam int MAX_OG  = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
  localparam int MAX_CYC = (MAX_OG > GAP_CYC) ? MAX_OG : GAP_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int ID_W    = $clog2(NUM_REQ);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_GAP} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CODE_W-1:0]   rem_q, rem_d;
  logic [ID_W-1:0]     grant_q, grant_d;
  logic                led_q, busy_q, done_q;
  logic                led_d, busy_d, done_d;

  logic [NUM_REQ-1:0]  elig;
  logic [CODE_W-1:0]   code_arr [NUM_REQ];
  logic                found;
  logic [ID_W-1:0]     pick, idx;
  logic [CODE_W-1:0]   pick_code;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    assign code_arr[i] = bus.code[i*CODE_W +: CODE_W];
    assign elig[i]     = bus.req[i] && (code_arr[i] != '0);
  end

  // Circular search starting just after the previous grantee gives round-robin fairness.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    found     = 1'b0;
    pick      = grant_q;
    pick_code = '0;
    idx       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((int'(grant_q) + k) % NUM_REQ);
      if (!found && elig[idx]) begin
        found     = 1'b1;
        pick      = idx;
        pick_code = code_arr[idx];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    rem_d   = rem_q;
    grant_d = grant_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (found) begin
          state_d = S_ON;
          grant_d = pick;
          rem_d   = pick_code - CODE_W'(1);
        end
      end
      S_ON: begin
        if (cnt_q == CNT_W'(ON_CYC - 1)) begin
          cnt_d = '0;
          if (rem_q == '0) begin
            state_d = S_GAP;
          end else begin
            state_d = S_OFF;
            rem_d   = rem_q - CODE_W'(1);
          end
        end
      end
      S_OFF: begin
        if (cnt_q == CNT_W'(OFF_CYC - 1)) begin
          cnt_d   = '0;
          state_d = S_ON;
        end
      end
      S_GAP: begin
        if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    // Outputs are derived from the next state so they can be registered without lag.
    led_d  = (state_d == S_ON);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_GAP) && (cnt_d == CNT_W'(GAP_CYC - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      grant_q <= ID_W'(NUM_REQ - 1);
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep all registers updating from pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      grant_q <= grant_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.led      = led_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.grant_id = grant_q;
endmodule

// File: tb/tb_led_code_arbiter.sv
// Self-checking bench for led_code_arbiter: directed scenarios plus random traffic
// compared cycle by cycle against a queue-based model of the expected LED sequence.
module tb_led_code_arbiter;
  localparam int ON_C  = 2;
  localparam int OFF_C = 3;
  localparam int GAP_C = 5;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  led_code_arbiter_if #(.NUM_REQ(4), .CODE_W(4)) bus ();

  led_code_arbiter #(
    .CLK_FREQ_KHz(1), .NUM_REQ(4), .CODE_W(4),
    .ON_MS(ON_C), .OFF_MS(OFF_C), .GAP_MS(GAP_C)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model: the remaining per-cycle LED values of the sequence in progress.
  bit         exp_q[$];
  int         exp_grant;
  logic       m_led, m_busy, m_done;
  logic [1:0] m_grant;

  function automatic void model_reset();
    exp_q.delete();
    exp_grant = 3;
    m_led = 0; m_busy = 0; m_done = 0; m_grant = 2'd3;
  endfunction

  function automatic void model_edge();
    if (exp_q.size() != 0) begin
      void'(exp_q.pop_front());
    end else begin
      for (int k = 1; k <= 4; k++) begin
        automatic int         i = (exp_grant + k) % 4;
        automatic logic [3:0] c = bus.code[i*4 +: 4];
        if (bus.req[i] === 1'b1 && c != 0) begin
          exp_grant = i;
          for (int p = 0; p < int'(c); p++) begin
            repeat (ON_C) exp_q.push_back(1'b1);
            if (p < int'(c) - 1) repeat (OFF_C) exp_q.push_back(1'b0);
          end
          repeat (GAP_C) exp_q.push_back(1'b0);
          break;
        end
      end
    end
    m_busy  = (exp_q.size() != 0);
    m_led   = m_busy ? exp_q[0] : 1'b0;
    m_done  = (exp_q.size() == 1);
    m_grant = exp_grant[1:0];
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy === 1'b1 && n < 200) begin
      cycle();
      n++;
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL wait_idle busy=%b still high after %0d cycles", bus.busy, n);
    end
  endtask

  task automatic test_reset();
    bus.req = '0; bus.code = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    checks++;
    if ({bus.led, bus.busy, bus.done, bus.grant_id} !== 5'b000_11) begin
      failures++;
      $display("FAIL reset_state got %b want 00011", {bus.led, bus.busy, bus.done, bus.grant_id});
    end
    apply_reset();
  endtask

  task automatic test_single();
    logic [16:0] pat = '0;
    int busy_n = 0, done_at = 0;
    bus.code = 16'h0003; bus.req = 4'b0001;
    for (int c = 1; c <= 22; c++) begin
      cycle();
      if (c == 1) bus.req = 4'b0000;
      checks++;
      if ({bus.led, bus.busy, bus.done, bus.grant_id} !== {m_led, m_busy, m_done, m_grant}) begin
        failures++;
        $display("FAIL single_c%0d got %b want %b", c,
                 {bus.led, bus.busy, bus.done, bus.grant_id}, {m_led, m_busy, m_done, m_grant});
      end
      if (bus.busy === 1'b1) begin
        busy_n++;
        pat = {pat[15:0], bus.led};
        if (bus.done === 1'b1) done_at = busy_n;
      end
    end
    checks++;
    if (pat !== 17'b11000110001100000) begin
      failures++;
      $display("FAIL single_pattern got %b want 11000110001100000", pat);
    end
    checks++;
    if (busy_n != 17 || done_at != 17) begin
      failures++;
      $display("FAIL single_busy busy=%0d done_at=%0d want 17/17", busy_n, done_at);
    end
    checks++;
    if (bus.grant_id !== 2'd0) begin
      failures++;
      $display("FAIL single_grant got %0d want 0", bus.grant_id);
    end
  endtask

  task automatic test_round_robin();
    int   grants[$];
    int   run = 0;
    logic prev_busy = 1'b0;
    apply_reset();
    bus.req = 4'b1111; bus.code = 16'h1111;
    for (int c = 1; c <= 45; c++) begin
      cycle();
      checks++;
      if ({bus.led, bus.busy, bus.done, bus.grant_id} !== {m_led, m_busy, m_done, m_grant}) begin
        failures++;
        $display("FAIL rr_c%0d got %b want %b", c,
                 {bus.led, bus.busy, bus.done, bus.grant_id}, {m_led, m_busy, m_done, m_grant});
      end
      if (bus.busy === 1'b1 && !prev_busy) grants.push_back(int'(bus.grant_id));
      if (bus.busy === 1'b1) run++;
      if (bus.busy === 1'b0 && prev_busy) begin
        checks++;
        if (run != 7) begin
          failures++;
          $display("FAIL rr_busy_len got %0d want 7", run);
        end
        run = 0;
      end
      prev_busy = bus.busy;
    end
    bus.req = '0;
    checks++;
    if (grants.size() < 5 || grants[0] != 0 || grants[1] != 1 || grants[2] != 2 ||
        grants[3] != 3 || grants[4] != 0) begin
      failures++;
      $display("FAIL rr_order got %p want 0,1,2,3,0", grants);
    end
    wait_idle();
  endtask

  task automatic test_zero_code();
    int   grants = 0, pulses = 0, bad = 0;
    logic prev_busy = 1'b0, prev_led = 1'b0;
    bus.req = 4'b0011; bus.code = 16'h0020;
    for (int c = 1; c <= 39; c++) begin
      cycle();
      checks++;
      if ({bus.led, bus.busy, bus.done, bus.grant_id} !== {m_led, m_busy, m_done, m_grant}) begin
        failures++;
        $display("FAIL zero_c%0d got %b want %b", c,
                 {bus.led, bus.busy, bus.done, bus.grant_id}, {m_led, m_busy, m_done, m_grant});
      end
      if (bus.busy === 1'b1 && !prev_busy) begin
        grants++;
        if (bus.grant_id !== 2'd1) bad++;
      end
      if (bus.led === 1'b1 && !prev_led) pulses++;
      prev_busy = bus.busy;
      prev_led  = bus.led;
    end
    bus.req = '0;
    checks++;
    if (grants != 3 || pulses != 6 || bad != 0) begin
      failures++;
      $display("FAIL zero_code grants=%0d pulses=%0d wrong_id=%0d want 3/6/0", grants, pulses, bad);
    end
  endtask

  task automatic test_non_preemptive();
    int   pulses = 0, busy_n = 0;
    logic prev_led = 1'b0;
    bus.req = 4'b0100; bus.code = 16'h0500;
    for (int c = 1; c <= 60; c++) begin
      cycle();
      checks++;
      if ({bus.led, bus.busy, bus.done, bus.grant_id} !== {m_led, m_busy, m_done, m_grant}) begin
        failures++;
        $display("FAIL nopre_c%0d got %b want %b", c,
                 {bus.led, bus.busy, bus.done, bus.grant_id}, {m_led, m_busy, m_done, m_grant});
      end
      if (bus.led === 1'b1 && !prev_led) pulses++;
      if (pulses == 2) begin
        bus.req = 4'b0000; bus.code = 16'h0100;
      end
      prev_led = bus.led;
      if (bus.busy === 1'b1) busy_n++;
      else if (busy_n > 0) break;
    end
    checks++;
    if (pulses != 5 || busy_n != 27 || bus.grant_id !== 2'd2) begin
      failures++;
      $display("FAIL nopre pulses=%0d busy=%0d grant=%0d want 5/27/2", pulses, busy_n, bus.grant_id);
    end
  endtask

  task automatic test_max_code();
    int   pulses = 0, busy_n = 0;
    logic prev_led = 1'b0;
    bus.req = 4'b0001; bus.code = 16'h000F;
    for (int c = 1; c <= 100; c++) begin
      cycle();
      if (c == 1) bus.req = 4'b0000;
      checks++;
      if ({bus.led, bus.busy, bus.done, bus.grant_id} !== {m_led, m_busy, m_done, m_grant}) begin
        failures++;
        $display("FAIL max_c%0d got %b want %b", c,
                 {bus.led, bus.busy, bus.done, bus.grant_id}, {m_led, m_busy, m_done, m_grant});
      end
      if (bus.led === 1'b1 && !prev_led) pulses++;
      prev_led = bus.led;
      if (bus.busy === 1'b1) busy_n++;
      else if (busy_n > 0) break;
    end
    checks++;
    if (pulses != 15 || busy_n != 77) begin
      failures++;
      $display("FAIL max_code pulses=%0d busy=%0d want 15/77", pulses, busy_n);
    end
  endtask

  task automatic test_random();
    for (int c = 1; c <= 800; c++) begin
      if ($urandom_range(7) == 0) begin
        bus.req  = 4'($urandom);
        bus.code = 16'($urandom);
      end
      cycle();
      checks++;
      if ({bus.led, bus.busy, bus.done, bus.grant_id} !== {m_led, m_busy, m_done, m_grant}) begin
        failures++;
        $display("FAIL rand_c%0d got %b want %b", c,
                 {bus.led, bus.busy, bus.done, bus.grant_id}, {m_led, m_busy, m_done, m_grant});
      end
    end
    bus.req = '0;
    wait_idle();
  endtask

  task automatic test_reset_mid();
    bus.req = 4'b0001; bus.code = 16'h0007;
    cycle();
    cycle();
    checks++;
    if (bus.led !== 1'b1 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL midrst_pre led=%b busy=%b want 1/1", bus.led, bus.busy);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({bus.led, bus.busy, bus.done, bus.grant_id} !== 5'b000_11) begin
      failures++;
      $display("FAIL midrst_async got %b want 00011", {bus.led, bus.busy, bus.done, bus.grant_id});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    cycle();
    checks++;
    if (bus.busy !== 1'b1 || bus.grant_id !== 2'd0 || bus.led !== 1'b1) begin
      failures++;
      $display("FAIL midrst_regrant busy=%b led=%b grant=%0d want 1/1/0",
               bus.busy, bus.led, bus.grant_id);
    end
    bus.req = '0;
    wait_idle();
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    bus.req  = '0;
    bus.code = '0;
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_zero_code();
    test_non_preemptive();
    test_max_code();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
